// File: rtl/display_pkg.sv
// Shared types and helpers for the LED matrix scan scheduler.
package display_pkg;

    localparam int NUM_COLS  = 8;
    localparam int SPLIT_COL = 4;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    typedef enum logic [1:0] {MODE_LEFT, MODE_RIGHT, MODE_SPLIT} mode_t;

    function automatic mode_t decode_mode(input logic left_req, input logic right_req);
        mode_t mode;
        case ({left_req, right_req})
            2'b10:   mode = MODE_LEFT;
            2'b01:   mode = MODE_RIGHT;
            default: mode = MODE_SPLIT;
        endcase
        return mode;
    endfunction

    function automatic logic col_from_left(input mode_t mode, input logic [2:0] col);
        return (mode == MODE_LEFT) || ((mode == MODE_SPLIT) && (col < 3'(SPLIT_COL)));
    endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Slot timer: counts 0..SCAN_DIV-1 while running, flags the blank window and slot end.
module scan_slot_counter #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    output logic o_blank_last,
    output logic o_slot_last,
    output logic o_in_blank
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LEN  = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cnt;

    // Held at zero while idle so every first slot starts with a full blank window.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == SLOT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_blank_last = (r_cnt == BLANK_LAST);
    assign o_slot_last  = (r_cnt == SLOT_LAST);
    assign o_in_blank   = (r_cnt < BLANK_LEN);

endmodule

// File: rtl/display_scan_scheduler.sv
// Shares the 8x8 LED matrix between two image sources, scanning one blanked column per slot.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_left_req,
    input  logic       i_right_req,
    input  logic [7:0] i_left_rows,
    input  logic [7:0] i_right_rows,
    output logic [2:0] o_col_addr,
    output logic       o_grant_left,
    output logic       o_grant_right,
    output logic [7:0] o_rows,
    output logic [2:0] o_col_sel,
    output logic       o_frame_done
);

    state_t     r_state;
    mode_t      r_mode;
    logic [2:0] r_col;
    logic [7:0] r_img;
    logic       r_grant_left;
    logic       r_grant_right;

    logic       w_blank_last;
    logic       w_slot_last;
    logic       w_in_blank;
    logic       w_any_req;
    logic       w_last_col;
    logic       w_frame_last;
    logic [7:0] w_src_rows;

    scan_slot_counter #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_slot (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_run       (r_state != IDLE),
        .o_blank_last(w_blank_last),
        .o_slot_last (w_slot_last),
        .o_in_blank  (w_in_blank)
    );

    assign w_any_req    = i_left_req | i_right_req;
    assign w_last_col   = (r_col == 3'(NUM_COLS - 1));
    assign w_frame_last = (r_state == SHOW) && w_slot_last && w_last_col;
    assign w_src_rows   = col_from_left(r_mode, r_col) ? i_left_rows : i_right_rows;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_mode        <= MODE_LEFT;
            r_col         <= '0;
            r_img         <= '0;
            r_grant_left  <= 1'b0;
            r_grant_right <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state       <= BLANK;
                        r_mode        <= decode_mode(i_left_req, i_right_req);
                        r_grant_left  <= i_left_req;
                        r_grant_right <= i_right_req;
                        r_col         <= '0;
                    end
                end
                BLANK: begin
                    if (w_blank_last) begin
                        r_img   <= w_src_rows;
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_slot_last) begin
                        if (w_last_col) begin
                            // Frame boundary: the only place the mode may change.
                            r_col         <= '0;
                            r_grant_left  <= i_left_req;
                            r_grant_right <= i_right_req;
                            if (w_any_req) begin
                                r_state <= BLANK;
                                r_mode  <= decode_mode(i_left_req, i_right_req);
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_col   <= r_col + 3'd1;
                            r_state <= BLANK;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rows        = ((r_state == SHOW) && !w_in_blank) ? r_img : 8'h00;
    assign o_col_sel     = r_col;
    assign o_col_addr    = r_col;
    assign o_grant_left  = r_grant_left;
    assign o_grant_right = r_grant_right;
    assign o_frame_done  = w_frame_last;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomised bench for display_scan_scheduler against a frame-time reference model.
module tb_display_scan_scheduler;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic       left_req;
    logic       right_req;
    logic [7:0] left_rows;
    logic [7:0] right_rows;
    logic [2:0] col_addr;
    logic       grant_left;
    logic       grant_right;
    logic [7:0] rows;
    logic [2:0] col_sel;
    logic       frame_done;

    logic [7:0] left_tab  [8];
    logic [7:0] right_tab [8];

    int n_checks = 0;
    int n_fail   = 0;
    int next_kind = -1;

    // Model: frame position in cycles since frame start, plus latched grants and image.
    bit         m_active;
    int         m_k;
    bit         m_gl;
    bit         m_gr;
    logic [7:0] m_img;

    display_scan_scheduler #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_left_req   (left_req),
        .i_right_req  (right_req),
        .i_left_rows  (left_rows),
        .i_right_rows (right_rows),
        .o_col_addr   (col_addr),
        .o_grant_left (grant_left),
        .o_grant_right(grant_right),
        .o_rows       (rows),
        .o_col_sel    (col_sel),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign left_rows  = left_tab[col_addr];
    assign right_rows = right_tab[col_addr];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_tables(input int kind);
        for (int c = 0; c < 8; c++) begin
            case (kind)
                0: begin
                    left_tab[c]  = 8'h01 << c;
                    right_tab[c] = 8'h80 >> c;
                end
                1: begin
                    left_tab[c]  = 8'hAA;
                    right_tab[c] = 8'h55;
                end
                default: begin
                    left_tab[c]  = 8'($urandom_range(1, 255));
                    right_tab[c] = 8'($urandom_range(1, 255));
                end
            endcase
        end
    endtask

    task automatic compare_outputs();
        int         col;
        int         ph;
        logic [7:0] exp_rows;
        col      = m_k / SD;
        ph       = m_k % SD;
        exp_rows = (m_active && ph >= BC) ? m_img : 8'h00;
        check_eq("rows", rows, exp_rows);
        check_eq("col_sel", 8'(col_sel), m_active ? 8'(col) : 8'h00);
        check_eq("col_addr", 8'(col_addr), m_active ? 8'(col) : 8'h00);
        check_eq("grant_left", 8'(grant_left), 8'(m_gl));
        check_eq("grant_right", 8'(grant_right), 8'(m_gr));
        check_eq("frame_done", 8'(frame_done), 8'(m_active && m_k == FRAME - 1));
    endtask

    task automatic model_advance();
        int col;
        int ph;
        if (reset) begin
            m_active = 0;
            m_k      = 0;
            m_gl     = 0;
            m_gr     = 0;
        end else if (!m_active) begin
            if (left_req || right_req) begin
                m_active = 1;
                m_k      = 0;
                m_gl     = left_req;
                m_gr     = right_req;
            end
        end else begin
            col = m_k / SD;
            ph  = m_k % SD;
            if (ph == BC - 1)
                m_img = (m_gl && (!m_gr || col < 4)) ? left_tab[col] : right_tab[col];
            if (m_k == FRAME - 1) begin
                m_k = 0;
                if (left_req || right_req) begin
                    m_gl = left_req;
                    m_gr = right_req;
                end else begin
                    m_active = 0;
                    m_gl     = 0;
                    m_gr     = 0;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic step(input logic l, input logic r, input logic rst);
        @(negedge clk);
        compare_outputs();
        left_req  = l;
        right_req = r;
        reset     = rst;
        if (next_kind >= 0) begin
            set_tables(next_kind);
            next_kind = -1;
        end
        model_advance();
    endtask

    task automatic run(input int n, input logic l, input logic r);
        for (int i = 0; i < n; i++) step(l, r, 1'b0);
    endtask

    task automatic wait_k(input string tag, input int target, input logic l, input logic r);
        int n;
        n = 0;
        while (!(m_active && m_k == target) && n < 300) begin
            step(l, r, 1'b0);
            n++;
        end
        check_eq(tag, 8'(n < 300), 8'd1);
    endtask

    initial begin
        reset     = 1'b1;
        left_req  = 1'b0;
        right_req = 1'b0;
        m_active  = 0;
        m_k       = 0;
        m_gl      = 0;
        m_gr      = 0;
        m_img     = 8'h00;
        set_tables(0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        run(20, 1'b0, 1'b0);

        // Left only with a walking-one image, two full frames and a bit.
        run(140, 1'b1, 1'b0);

        // Split halves with constant AA/55 sources.
        next_kind = 1;
        run(80, 1'b1, 1'b1);

        // Right request arrives during column 2 of a left frame.
        next_kind = 0;
        wait_k("wait_left_frame", 0, 1'b1, 1'b0);
        run(8, 1'b1, 1'b0);
        wait_k("wait_col2", 2 * SD + 3, 1'b1, 1'b0);
        run(100, 1'b1, 1'b1);

        // All requests drop mid-frame.
        wait_k("wait_release", 20, 1'b1, 1'b1);
        run(80, 1'b0, 1'b0);

        // Reset during SHOW of column 5, request kept high.
        next_kind = 2;
        wait_k("wait_col5_show", 5 * SD + 4, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run(40, 1'b1, 1'b0);

        begin
            logic l;
            logic r;
            logic rst;
            l = 1'b1;
            r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    l = 1'($urandom_range(0, 1));
                    r = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 5) == 0) next_kind = 2;
                rst = ($urandom_range(0, 299) == 0);
                step(l, r, rst);
            end
        end

        step(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
